// File: rtl/fwrisc_mem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | fwrisc_mem_arb_pkg                                                   |
// | Shared types and port identifiers for the fetch/data memory arbiter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fwrisc_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fwrisc_mem_arb_wdog.sv
// +----------------------------------------------------------------------+
// | fwrisc_mem_arb_wdog                                                  |
// | Bus-wait watchdog: counts granted cycles, flags the final allowed one.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fwrisc_mem_arb_wdog #(
  parameter int TIMEOUT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_wdog_off
      logic w_unused;
      assign w_unused = clock ^ reset ^ clear ^ enable;
      assign expire   = 1'b0;
    end else begin : g_wdog_on
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] r_count;

      // Saturates at the last cycle so a held enable never wraps back to zero
      always_ff @(posedge clock) begin
        if (reset || clear)
          r_count <= '0;
        else if (enable && (r_count != C_LAST))
          r_count <= r_count + 1'b1;
      end

      assign expire = enable && (r_count == C_LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/fwrisc_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | fwrisc_mem_arbiter                                                   |
// | Shares one memory bus between instruction fetch and data ports.      |
// | Optional round-robin on collisions: define FWRISC_MEM_ARB_RR_EN.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fwrisc_mem_arbiter
  import fwrisc_mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ivalid,
  input  logic [31:0] iaddr,
  output logic        iready,
  output logic [31:0] irdata,
  output logic        ierr,
  input  logic        dvalid,
  input  logic [31:0] daddr,
  input  logic        dwrite,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  output logic        dready,
  output logic [31:0] drdata,
  output logic        derr,
  output logic        mvalid,
  output logic [31:0] maddr,
  output logic        mwrite,
  output logic [31:0] mwdata,
  output logic [3:0]  mwstb,
  input  logic        mready,
  input  logic [31:0] mrdata
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       w_granted;
  logic       w_expire;
  logic       w_timeout;
  logic       w_pick_data;

  assign w_granted = (r_state == GNT_I) || (r_state == GNT_D);
  // A completing bus beat always beats the watchdog
  assign w_timeout = w_expire && !mready;

  fwrisc_mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (r_state == IDLE),
    .enable (w_granted),
    .expire (w_expire)
  );

`ifdef FWRISC_MEM_ARB_RR_EN
  logic r_rr_last;

  always_ff @(posedge clock) begin
    if (reset)
      r_rr_last <= FETCH;
    else if ((r_state == IDLE) && (w_state_nxt == GNT_D))
      r_rr_last <= DATA;
    else if ((r_state == IDLE) && (w_state_nxt == GNT_I))
      r_rr_last <= FETCH;
  end

  assign w_pick_data = (r_rr_last == FETCH);
`else
  assign w_pick_data = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    iready      = 1'b0;
    irdata      = '0;
    ierr        = 1'b0;
    dready      = 1'b0;
    drdata      = '0;
    derr        = 1'b0;
    mvalid      = 1'b0;
    maddr       = '0;
    mwrite      = 1'b0;
    mwdata      = '0;
    mwstb       = '0;

    case (r_state)
      IDLE: begin
        if (dvalid && ivalid)
          w_state_nxt = w_pick_data ? GNT_D : GNT_I;
        else if (dvalid)
          w_state_nxt = GNT_D;
        else if (ivalid)
          w_state_nxt = GNT_I;
      end

      GNT_I: begin
        mvalid = !w_timeout;
        maddr  = iaddr;
        if (mready) begin
          iready      = 1'b1;
          irdata      = mrdata;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          iready      = 1'b1;
          ierr        = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      GNT_D: begin
        mvalid = !w_timeout;
        maddr  = daddr;
        mwrite = dwrite;
        mwdata = dwdata;
        mwstb  = dwstb;
        if (mready) begin
          dready      = 1'b1;
          drdata      = mrdata;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          dready      = 1'b1;
          derr        = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fwrisc_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_fwrisc_mem_arbiter                                                |
// | Randomised scoreboard bench for the fetch/data memory arbiter.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fwrisc_mem_arbiter;
  import fwrisc_mem_arb_pkg::*;

  localparam int TO = 8;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic [31:0] bus_rdata;
    int          delay;
    int          grant_cyc;
    int          done_cyc;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        ivalid, dvalid, dwrite, mready;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic [3:0]  dwstb;
  logic        iready, ierr, dready, derr, mvalid, mwrite;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic [3:0]  mwstb;

  fwrisc_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .ivalid(ivalid), .iaddr(iaddr), .iready(iready), .irdata(irdata), .ierr(ierr),
    .dvalid(dvalid), .daddr(daddr), .dwrite(dwrite), .dwdata(dwdata), .dwstb(dwstb),
    .dready(dready), .drdata(drdata), .derr(derr),
    .mvalid(mvalid), .maddr(maddr), .mwrite(mwrite), .mwdata(mwdata), .mwstb(mwstb),
    .mready(mready), .mrdata(mrdata)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  txn_t exp_q[$];
  txn_t plan_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b1;
  logic m_rr_last = FETCH;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Bus responder: follows the per-transaction plan, junk mready while idle
  initial begin : responder
    txn_t rcur;
    bit   busy = 1'b0;
    int   gcyc = 0;
    mready = 1'b0;
    mrdata = '0;
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        busy   = 1'b0;
        mready = 1'b0;
      end else begin
        if (busy) begin
          if (gcyc == rcur.delay || gcyc == TO - 1) busy = 1'b0;
          else gcyc++;
        end
        if (!busy && mvalid && plan_q.size() > 0) begin
          rcur = plan_q.pop_front();
          busy = 1'b1;
          gcyc = 0;
        end
        if (busy) begin
          mready = (gcyc == rcur.delay);
          mrdata = mready ? rcur.bus_rdata : $urandom;
        end else begin
          mready = 1'($urandom_range(0, 1));
          mrdata = $urandom;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each grant/completion
  txn_t cur;
  bit   mon_busy   = 1'b0;
  bit   prev_ready = 1'b0;
  always @(negedge clock) begin
    if (!mon_en) begin
      mon_busy   = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_ready) check("idle_gap_mvalid", 32'(mvalid), 0);
      if (!mon_busy && mvalid) begin
        if (exp_q.size() == 0) check("unexpected_grant", 1, 0);
        else begin
          cur      = exp_q[0];
          mon_busy = 1'b1;
          check("grant_cycle", cyc, cur.grant_cyc);
          check("maddr", maddr, cur.addr);
          check("mwrite", 32'(mwrite), 32'(cur.wr));
          check("mwstb", 32'(mwstb), 32'(cur.wstb));
          if (cur.wr) check("mwdata", mwdata, cur.wdata);
        end
      end
      if (iready || dready) begin
        if (!mon_busy) check("spurious_ready", {30'd0, iready, dready}, 0);
        else begin : done_chk
          logic        err;
          logic [31:0] rd;
          err = (cur.delay >= TO);
          rd  = err ? 32'd0 : cur.bus_rdata;
          check("ready_port", {30'd0, iready, dready}, (cur.port == DATA) ? 32'd1 : 32'd2);
          check("done_cycle", cyc, cur.done_cyc);
          check("rdata", (cur.port == DATA) ? drdata : irdata, rd);
          check("err", 32'((cur.port == DATA) ? derr : ierr), 32'(err));
          check("mvalid_at_done", 32'(mvalid), 32'(!err));
          void'(exp_q.pop_front());
          mon_busy = 1'b0;
        end
      end
      prev_ready = iready | dready;
    end
  end

  function automatic txn_t rand_txn(input logic port);
    txn_t t;
    t.port      = port;
    t.addr      = $urandom;
    t.wr        = (port == DATA) ? 1'($urandom_range(0, 1)) : 1'b0;
    t.wdata     = $urandom;
    t.wstb      = (port == DATA) ? 4'($urandom_range(0, 15)) : 4'd0;
    t.bus_rdata = $urandom;
    t.delay     = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 12);
    t.grant_cyc = 0;
    t.done_cyc  = 0;
    return t;
  endfunction

  function automatic logic first_port();
`ifdef FWRISC_MEM_ARB_RR_EN
    return (m_rr_last == FETCH) ? DATA : FETCH;
`else
    return DATA;
`endif
  endfunction

  // Called at posedge+1; predicts grant order and timing, then runs the handshake
  task automatic issue(input bit wi, input bit wd, input txn_t ti, input txn_t td);
    txn_t order[$];
    int   t;
    bit   pend_i, pend_d, di, dd;
    if (wi && wd) begin
      if (first_port() == DATA) begin order.push_back(td); order.push_back(ti); end
      else begin order.push_back(ti); order.push_back(td); end
    end else if (wd) order.push_back(td);
    else if (wi) order.push_back(ti);
    t = cyc + 1;
    foreach (order[j]) begin
      order[j].grant_cyc = t;
      order[j].done_cyc  = t + ((order[j].delay < TO) ? order[j].delay : TO - 1);
      t = order[j].done_cyc + 2;
      m_rr_last = order[j].port;
      exp_q.push_back(order[j]);
      plan_q.push_back(order[j]);
    end
    if (wi) begin ivalid = 1'b1; iaddr = ti.addr; end
    if (wd) begin
      dvalid = 1'b1; daddr = td.addr; dwrite = td.wr; dwdata = td.wdata; dwstb = td.wstb;
    end
    pend_i = wi;
    pend_d = wd;
    for (int n = 0; n < 80 && (pend_i || pend_d); n++) begin
      @(negedge clock);
      di = iready && pend_i;
      dd = dready && pend_d;
      if (di) pend_i = 1'b0;
      if (dd) pend_d = 1'b0;
      @(posedge clock);
      #1;
      if (di) ivalid = 1'b0;
      if (dd) dvalid = 1'b0;
    end
    if (pend_i || pend_d) begin
      check("handshake_timeout", {30'd0, pend_i, pend_d}, 0);
      finish_tb();
    end
  endtask

  initial begin : stim
    txn_t ti, td;
    bit   wi, wd;
    reset = 1'b1;
    ivalid = 1'b0; iaddr = '0;
    dvalid = 1'b0; daddr = '0; dwrite = 1'b0; dwdata = '0; dwstb = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_mvalid", 32'(mvalid), 0);
    check("rst_ready", {30'd0, iready, dready}, 0);
    check("rst_err", {30'd0, ierr, derr}, 0);
    check("rst_maddr", maddr, 0);
    check("rst_rdata", irdata | drdata, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Directed store with two wait cycles
    td = rand_txn(DATA);
    td.addr = 32'h8000_0010; td.wr = 1'b1; td.wdata = 32'hDEAD_BEEF; td.wstb = 4'hF; td.delay = 2;
    issue(1'b0, 1'b1, ti, td);

    // Simultaneous requests, five rounds
    for (int r = 0; r < 5; r++) issue(1'b1, 1'b1, rand_txn(FETCH), rand_txn(DATA));

    // Watchdog: full timeout, then mready on the last allowed cycle
    ti = rand_txn(FETCH); ti.delay = 20;
    issue(1'b1, 1'b0, ti, td);
    ti = rand_txn(FETCH); ti.delay = TO - 1;
    issue(1'b1, 1'b0, ti, td);
    td = rand_txn(DATA); td.delay = TO;
    issue(1'b0, 1'b1, ti, td);

    for (int r = 0; r < 150; r++) begin
      wi = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      if (!wi && !wd) wd = 1'b1;
      issue(wi, wd, rand_txn(FETCH), rand_txn(DATA));
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    check("queue_drained", exp_q.size(), 0);

    // Reset in the middle of a data grant abandons it silently
    mon_en = 1'b0;
    td = rand_txn(DATA); td.delay = 100;
    plan_q.push_back(td);
    dvalid = 1'b1; daddr = td.addr; dwrite = td.wr; dwdata = td.wdata; dwstb = td.wstb;
    @(posedge clock); #1;
    @(negedge clock);
    check("rstmid_granted", 32'(mvalid), 1);
    @(posedge clock); #1;
    reset = 1'b1; dvalid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_rr_last = FETCH;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("rstmid_mvalid", 32'(mvalid), 0);
      check("rstmid_dready", 32'(dready), 0);
    end
    plan_q.delete();
    @(posedge clock); #1;
    mon_en = 1'b1;
    issue(1'b1, 1'b1, rand_txn(FETCH), rand_txn(DATA));
    check("queue_drained_end", exp_q.size(), 0);
    finish_tb();
  end

  initial begin : watchdog_limit
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    finish_tb();
  end

endmodule

`default_nettype wire
